// File: rtl/reset_release_sequencer.sv
// ---------------------------------------------------------------------------
// reset_release_sequencer
//
// Produces staged, synchronously released active-low domain resets. Assertion
// of reset_n clears every output asynchronously. Release is staged:
// reset_n synchronizer -> stretch counter -> per-domain release ladder
// (bit 0 first, one bit every GAP_CYCLES edges). In RUN, a debug ndreset
// request pulls all domains back into reset. Dropping the request re-runs the
// stretch and the ladder, but not the synchronizer.
//
// Parameters
//   SYNC_STAGES    (>=2) synchronizer depth on reset_n release
//   STRETCH_CYCLES (>=1) cycles held after synchronized release
//   NUM_DOMAINS    (>=1) number of domain reset outputs
//   GAP_CYCLES     (>=1) cycles between successive domain releases
//
// Ports
//   clock           in   block clock
//   reset_n         in   external reset, async assert, active-low
//   ndreset_req     in   debug reset request (level, synchronous)
//   ndreset_ack     out  high while the ndreset request is honoured
//   domain_reset_n  out  [NUM_DOMAINS] per-domain active-low resets
//   all_released    out  high once every domain is out of reset
//   busy            out  high in any state other than RUN
//   reset_cause     out  [2] (only with RESET_SEQ_CAUSE_EN defined)
//                        2'b01 external/power-on, 2'b10 debug ndreset
//
// Optional feature macro: RESET_SEQ_CAUSE_EN
// ---------------------------------------------------------------------------
module reset_release_sequencer #(
    parameter int SYNC_STAGES    = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int NUM_DOMAINS    = 3,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ndreset_req,
    output logic                   ndreset_ack,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   all_released,
    output logic                   busy
`ifdef RESET_SEQ_CAUSE_EN
    ,
    output logic [1:0]             reset_cause
`endif
);

    localparam int CNT_MAX = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // The state register itself acts as the final synchronizer stage, so the
    // explicit chain is one flop shorter than SYNC_STAGES.
    localparam int SW      = SYNC_STAGES - 1;

    localparam logic [CW-1:0]          CNT_SAT      = CW'(CNT_MAX);
    localparam logic [CW-1:0]          CNT_ONE      = CW'(1);
    localparam logic [CW-1:0]          STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0]          GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE      = NUM_DOMAINS'(1);
    localparam logic [SW-1:0]          SYNC_ONE     = SW'(1);

    localparam logic [1:0] CAUSE_EXT   = 2'b01;
    localparam logic [1:0] CAUSE_DEBUG = 2'b10;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_STRETCH = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   all_q, all_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic [CW-1:0]          cnt_inc_s;
    logic [NUM_DOMAINS-1:0] dom_step_s;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0]             cause_q, cause_d;
`endif

    // Saturating counter increment and next-domain release pattern.
    always_comb begin
        if (cnt_q == CNT_SAT) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
        end
        // Releasing from all-zero yields bit 0, so STRETCH and RELEASE share it.
        dom_step_s = (dom_q << 1) | DOM_ONE;
        sync_d     = (sync_q << 1) | SYNC_ONE;
    end

    // Next-state and registered-output logic of the release sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        all_d   = all_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
`ifdef RESET_SEQ_CAUSE_EN
        cause_d = cause_q;
`endif
        case (state_q)
            ST_SYNC: begin
                // Top chain bit already high: this edge completes SYNC_STAGES.
                if (sync_q[SW-1]) begin
                    state_d = ST_STRETCH;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_STRETCH, ST_RELEASE: begin
                if (((state_q == ST_STRETCH) && (cnt_q == STRETCH_LAST)) ||
                    ((state_q == ST_RELEASE) && (cnt_q == GAP_LAST))) begin
                    dom_d = dom_step_s;
                    cnt_d = {CW{1'b0}};
                    if (dom_step_s[NUM_DOMAINS-1]) begin
                        state_d = ST_RUN;
                        all_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RUN: begin
                if (ndreset_req) begin
                    state_d = ST_HOLD;
                    dom_d   = {NUM_DOMAINS{1'b0}};
                    all_d   = 1'b0;
                    busy_d  = 1'b1;
                    ack_d   = 1'b1;
`ifdef RESET_SEQ_CAUSE_EN
                    cause_d = CAUSE_DEBUG;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                // Exit skips the synchronizer; the chain is still all ones.
                if (!ndreset_req) begin
                    state_d = ST_STRETCH;
                    ack_d   = 1'b0;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_SYNC;
                cnt_d   = {CW{1'b0}};
                dom_d   = {NUM_DOMAINS{1'b0}};
                all_d   = 1'b0;
                ack_d   = 1'b0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // State, synchronizer and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SYNC;
            sync_q  <= {SW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            dom_q   <= {NUM_DOMAINS{1'b0}};
            all_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef RESET_SEQ_CAUSE_EN
            cause_q <= CAUSE_EXT;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            all_q   <= all_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef RESET_SEQ_CAUSE_EN
            cause_q <= cause_d;
`endif
        end
    end

    assign domain_reset_n = dom_q;
    assign all_released   = all_q;
    assign ndreset_ack    = ack_q;
    assign busy           = busy_q;
`ifdef RESET_SEQ_CAUSE_EN
    assign reset_cause    = cause_q;
`endif

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer: default instance plus a
// small corner instance (SYNC_STAGES=2, STRETCH_CYCLES=1, NUM_DOMAINS=1).
module tb_reset_release_sequencer;

    localparam int S  = 3;
    localparam int ST = 16;
    localparam int N  = 3;
    localparam int G  = 4;
    localparam int C_FIRST = 3;   // corner: 2 sync + 1 stretch

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n;
    logic         req;
    logic         req_c;
    logic         ack, all_rel, busy;
    logic [N-1:0] dom;
    logic         ack_c, all_c, busy_c;
    logic [0:0]   dom_c;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0]   cause, cause_c;
`endif

    int checks = 0;
    int errors = 0;

    reset_release_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ndreset_req    (req),
        .ndreset_ack    (ack),
        .domain_reset_n (dom),
        .all_released   (all_rel),
        .busy           (busy)
`ifdef RESET_SEQ_CAUSE_EN
        , .reset_cause  (cause)
`endif
    );

    reset_release_sequencer #(
        .SYNC_STAGES(2), .STRETCH_CYCLES(1), .NUM_DOMAINS(1), .GAP_CYCLES(1)
    ) dut_c (
        .clock          (clock),
        .reset_n        (reset_n),
        .ndreset_req    (req_c),
        .ndreset_ack    (ack_c),
        .domain_reset_n (dom_c),
        .all_released   (all_c),
        .busy           (busy_c)
`ifdef RESET_SEQ_CAUSE_EN
        , .reset_cause  (cause_c)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k: edges since the reference point; domain i is out of reset when
    // m_k >= m_off + i*G (m_off = S+ST after reset_n, ST after HOLD exit).
    int         m_k   = 0;
    int         m_off = S + ST;
    int         m_kc  = 0;
    bit         m_hold = 1'b0;
    logic [1:0] m_cause = 2'b01;

    function automatic bit m_rel(input int i);
        return !m_hold && (m_k >= m_off + i * G);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_k     <= 0;
            m_kc    <= 0;
            m_off   <= S + ST;
            m_hold  <= 1'b0;
            m_cause <= 2'b01;
        end else begin
            m_kc <= m_kc + 1;
            if (m_hold) begin
                if (!req) begin
                    m_hold <= 1'b0;
                    m_k    <= 0;
                    m_off  <= ST;
                end
            end else if (m_rel(N - 1) && req) begin
                m_hold  <= 1'b1;
                m_cause <= 2'b10;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clock) begin
        logic [N-1:0] ed;
        for (int i = 0; i < N; i++) ed[i] = m_rel(i);
        chk("model_dom",  32'(dom),     32'(ed));
        chk("model_all",  32'(all_rel), 32'(m_rel(N - 1)));
        chk("model_busy", 32'(busy),    32'(!m_rel(N - 1)));
        chk("model_ack",  32'(ack),     32'(m_hold));
        chk("model_cdom", 32'(dom_c),   32'(m_kc >= C_FIRST));
        chk("model_call", 32'(all_c),   32'(m_kc >= C_FIRST));
        chk("model_cbsy", 32'(busy_c),  32'(m_kc < C_FIRST));
        chk("model_cack", 32'(ack_c),   32'h0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("model_cause", 32'(cause), 32'(m_cause));
        chk("model_ccaus", 32'(cause_c), 32'h1);
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_dom, input bit e_all,
                           input bit e_ack);
        chk({tag, "_dom"},  32'(dom),     32'(e_dom));
        chk({tag, "_all"},  32'(all_rel), 32'(e_all));
        chk({tag, "_busy"}, 32'(busy),    32'(!e_all));
        chk({tag, "_ack"},  32'(ack),     32'(e_ack));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        req     = 1'b0;
        req_c   = 1'b0;
        #1 reset_n = 1'b0;
        step(3);
        chk_out("rst", 3'b000, 1'b0, 1'b0);

        // Run A: interrupted by reset at edge 21; corner instance at edge 3.
        reset_n = 1'b1;
        step(2);
        chk("c_e2_dom", 32'(dom_c), 32'h0);
        step(1);
        chk("c_e3_dom", 32'(dom_c), 32'h1);
        chk("c_e3_all", 32'(all_c), 32'h1);
        step(18);
        chk_out("a_e21", 3'b001, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk_out("a_async", 3'b000, 1'b0, 1'b0);
        chk("a_async_cdom", 32'(dom_c), 32'h0);
        step(2);

        // Run B: full power-on timing.
        reset_n = 1'b1;
        step(18); chk_out("b_e18", 3'b000, 1'b0, 1'b0);
        step(1);  chk_out("b_e19", 3'b001, 1'b0, 1'b0);
        step(3);  chk_out("b_e22", 3'b001, 1'b0, 1'b0);
        step(1);  chk_out("b_e23", 3'b011, 1'b0, 1'b0);
        step(3);  chk_out("b_e26", 3'b011, 1'b0, 1'b0);
        step(1);  chk_out("b_e27", 3'b111, 1'b1, 1'b0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("b_cause_por", 32'(cause), 32'h1);
`endif
        // ndreset handshake: req high for edges 28..32.
        req = 1'b1;
        step(1);  chk_out("b_e28", 3'b000, 1'b0, 1'b1);
`ifdef RESET_SEQ_CAUSE_EN
        chk("b_cause_dbg", 32'(cause), 32'h2);
`endif
        step(4);  chk_out("b_e32", 3'b000, 1'b0, 1'b1);
        req = 1'b0;
        step(1);  chk_out("b_e33", 3'b000, 1'b0, 1'b0);
        step(15); chk_out("b_x15", 3'b000, 1'b0, 1'b0);
        step(1);  chk_out("b_x16", 3'b001, 1'b0, 1'b0);
        step(4);  chk_out("b_x20", 3'b011, 1'b0, 1'b0);
        step(4);  chk_out("b_x24", 3'b111, 1'b1, 1'b0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("b_cause_run", 32'(cause), 32'h2);
`endif

        // Sub-cycle reset glitch still clears everything.
        #1 reset_n = 1'b0;
        #1 chk_out("g_low", 3'b000, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        #1 chk_out("g_high", 3'b000, 1'b0, 1'b0);
`ifdef RESET_SEQ_CAUSE_EN
        chk("g_cause", 32'(cause), 32'h1);
`endif

        // Run C: early ndreset from edge 10 ignored until RUN.
        step(9);
        req = 1'b1;
        step(18); chk_out("c_e27", 3'b111, 1'b1, 1'b0);
        step(1);  chk_out("c_e28", 3'b000, 1'b0, 1'b1);
        req = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
